// File: rtl/sram_axi_bridge_pkg.sv
// rtl/sram_axi_bridge_pkg.sv - shared FSM encodings, ID tags and AXI constants for the sram-to-AXI bridge
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } w_state_t;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } rd_src_t;

  localparam logic [3:0] DEF_INST_RID = 4'd0;
  localparam logic [3:0] DEF_DATA_RID = 4'd1;
  localparam logic [3:0] DEF_WR_ID    = 4'd1;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

  function automatic logic [2:0] to_axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - bridges the core's inst and data sram-like ports onto one AXI3 master
// One outstanding read (data > inst priority) and one outstanding write; data port stays in issue order.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_RID = DEF_INST_RID,
  parameter logic [3:0] DATA_RID = DEF_DATA_RID,
  parameter logic [3:0] WR_ID    = DEF_WR_ID
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  r_state_t    r_state;
  rd_src_t     r_src;
  logic [31:0] ar_addr_q;
  logic [1:0]  ar_size_q;
  logic        arvalid_q;
  logic        rready_q;

  w_state_t    w_state;
  logic [31:0] aw_addr_q;
  logic [1:0]  aw_size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;

  logic r_idle;
  logic w_idle;
  logic data_rd_req;
  logic data_wr_req;
  logic data_rd_busy;
  logic data_rd_grant;
  logic inst_grant;
  logic wr_grant;
  logic r_fire;
  logic b_fire;
  logic aw_clear;
  logic w_clear;

  // IDs and status responses carry no information for a single-outstanding design.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  assign r_idle       = (r_state == R_IDLE);
  assign w_idle       = (w_state == W_IDLE);
  assign data_rd_req  = data_sram_req & ~data_sram_wr;
  assign data_wr_req  = data_sram_req &  data_sram_wr;
  assign data_rd_busy = ~r_idle & (r_src == SRC_DATA);

  // Reads wait for any outstanding write so a read-after-write never overtakes it.
  assign data_rd_grant = r_idle & w_idle & data_rd_req;
  assign inst_grant    = r_idle & w_idle & inst_sram_req & ~data_rd_req;
  assign wr_grant      = w_idle & data_wr_req & ~data_rd_busy;

  assign r_fire = (r_state == R_R) & rvalid;
  assign b_fire = (w_state == W_B) & bvalid;

  assign inst_sram_addr_ok = resetn & inst_grant;
  assign data_sram_addr_ok = resetn & (data_rd_grant | wr_grant);
  assign inst_sram_data_ok = resetn & r_fire & (r_src == SRC_INST);
  assign data_sram_data_ok = resetn & ((r_fire & (r_src == SRC_DATA)) | b_fire);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      r_src     <= SRC_INST;
      ar_addr_q <= 32'd0;
      ar_size_q <= 2'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_grant) begin
            r_src     <= SRC_DATA;
            ar_addr_q <= data_sram_addr;
            ar_size_q <= data_sram_size;
            arvalid_q <= 1'b1;
            r_state   <= R_AR;
          end else if (inst_grant) begin
            r_src     <= SRC_INST;
            ar_addr_q <= inst_sram_addr;
            ar_size_q <= inst_sram_size;
            arvalid_q <= 1'b1;
            r_state   <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state   <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          r_state   <= R_IDLE;
        end
      endcase
    end
  end

  // A channel is finished once its valid has been accepted or dropped.
  assign aw_clear = ~awvalid_q | awready;
  assign w_clear  = ~wvalid_q  | wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state   <= W_IDLE;
      aw_addr_q <= 32'd0;
      aw_size_q <= 2'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_grant) begin
            aw_addr_q <= data_sram_addr;
            aw_size_q <= data_sram_size;
            wstrb_q   <= data_sram_wstrb;
            wdata_q   <= data_sram_wdata;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state   <= W_AW;
          end
        end
        W_AW: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_clear && w_clear) begin
            bready_q <= 1'b1;
            w_state  <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          w_state   <= W_IDLE;
        end
      endcase
    end
  end

  assign arid    = (r_src == SRC_DATA) ? DATA_RID : INST_RID;
  assign araddr  = ar_addr_q;
  assign arsize  = to_axi_size(ar_size_q);
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NONE;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign awid    = WR_ID;
  assign awaddr  = aw_addr_q;
  assign awsize  = to_axi_size(aw_size_q);
  assign awvalid = awvalid_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NONE;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

  assign wid     = WR_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule
